// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage datapath for a 5-stage MIPS pipeline.
//   - Decodes the ALU operation from alu_op/funct.
//   - 32-bit (DATA_W) ALU with an 8-bit status word.
//   - ID-stage branch-compare forwarding: select, operand mux, equality.
//   - EX/MEM-style register holding result_q/status_q.
// Decode, ALU and forwarding are combinational. result_q/status_q are
// registered.
//
// Build option: define ALU_SHIFT_EN to implement SLL/SRL/SRA. Without it,
// funct 00/02/03 decode as INVALID and no shifter is built.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   alu_op, funct, shamt    operation class, R-type funct, shift amount
//   src_a, src_b            ALU operands
//   ex_en                   capture enable for result_q/status_q
//   id_ex_*/ex_mem_*/if_id_* pipeline hazard information
//   rf_data1/2              register-file read data
//   mem_fwd_data            MEM-stage forwarding value
//   alu_ctrl                decoded ALU operation (combinational)
//   alu_result, alu_status  ALU result and flags (combinational)
//   result_q, status_q      registered result and flags
//   fwd_sel1/2              forwarding selects (combinational)
//   fwd_data1/2             forwarded branch-compare operands (combinational)
//   regs_equal              fwd_data1 == fwd_data2 (combinational)
module alu_exec_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            alu_op,
    input  logic [5:0]            funct,
    input  logic [4:0]            shamt,
    input  logic [DATA_W-1:0]     src_a,
    input  logic [DATA_W-1:0]     src_b,
    input  logic                  ex_en,
    input  logic                  id_ex_regwrite,
    input  logic                  ex_mem_regwrite,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic [DATA_W-1:0]     rf_data1,
    input  logic [DATA_W-1:0]     rf_data2,
    input  logic [DATA_W-1:0]     mem_fwd_data,
    output logic [3:0]            alu_ctrl,
    output logic [DATA_W-1:0]     alu_result,
    output logic [7:0]            alu_status,
    output logic [DATA_W-1:0]     result_q,
    output logic [7:0]            status_q,
    output logic [1:0]            fwd_sel1,
    output logic [1:0]            fwd_sel2,
    output logic [DATA_W-1:0]     fwd_data1,
    output logic [DATA_W-1:0]     fwd_data2,
    output logic                  regs_equal
);

    localparam int unsigned MSB = DATA_W - 1;

    localparam logic [3:0] CTRL_AND  = 4'h0;
    localparam logic [3:0] CTRL_OR   = 4'h1;
    localparam logic [3:0] CTRL_ADD  = 4'h2;
    localparam logic [3:0] CTRL_XOR  = 4'h3;
    localparam logic [3:0] CTRL_NOR  = 4'h4;
    localparam logic [3:0] CTRL_SUB  = 4'h6;
    localparam logic [3:0] CTRL_SLT  = 4'h7;
    localparam logic [3:0] CTRL_SLTU = 4'hA;
    localparam logic [3:0] CTRL_ADDU = 4'hB;
    localparam logic [3:0] CTRL_SUBU = 4'hC;
    localparam logic [3:0] CTRL_INV  = 4'hF;
`ifdef ALU_SHIFT_EN
    localparam logic [3:0] CTRL_SLL  = 4'h5;
    localparam logic [3:0] CTRL_SRL  = 4'h8;
    localparam logic [3:0] CTRL_SRA  = 4'h9;
`else
    // shamt only feeds the shifter; keep it referenced when no shifter is built
    logic unused_shamt;
    assign unused_shamt = ^shamt;
`endif

    // ALU operation decode
    always_comb begin
        alu_ctrl = CTRL_INV;
        case (alu_op)
            2'b00: alu_ctrl = CTRL_ADD;
            2'b01: alu_ctrl = CTRL_SUB;
            2'b11: alu_ctrl = CTRL_AND;
            default: begin
                case (funct)
                    6'h20:   alu_ctrl = CTRL_ADD;
                    6'h21:   alu_ctrl = CTRL_ADDU;
                    6'h22:   alu_ctrl = CTRL_SUB;
                    6'h23:   alu_ctrl = CTRL_SUBU;
                    6'h24:   alu_ctrl = CTRL_AND;
                    6'h25:   alu_ctrl = CTRL_OR;
                    6'h26:   alu_ctrl = CTRL_XOR;
                    6'h27:   alu_ctrl = CTRL_NOR;
                    6'h2A:   alu_ctrl = CTRL_SLT;
                    6'h2B:   alu_ctrl = CTRL_SLTU;
`ifdef ALU_SHIFT_EN
                    6'h00:   alu_ctrl = CTRL_SLL;
                    6'h02:   alu_ctrl = CTRL_SRL;
                    6'h03:   alu_ctrl = CTRL_SRA;
`endif
                    default: alu_ctrl = CTRL_INV;
                endcase
            end
        endcase
    end

    // One extra bit holds carry-out (add) or borrow (sub; clear means a >= b)
    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;
    logic            add_ovf;
    logic            sub_ovf;
    logic            slt;
    logic            sltu;

    assign sum_ext  = {1'b0, src_a} + {1'b0, src_b};
    assign diff_ext = {1'b0, src_a} - {1'b0, src_b};
    assign add_ovf  = (src_a[MSB] == src_b[MSB]) && (sum_ext[MSB] != src_a[MSB]);
    assign sub_ovf  = (src_a[MSB] != src_b[MSB]) && (diff_ext[MSB] != src_a[MSB]);
    assign slt      = $signed(src_a) < $signed(src_b);
    assign sltu     = src_a < src_b;

    logic ovf;
    logic carry;
    logic invalid;

    // ALU datapath
    always_comb begin
        alu_result = '0;
        ovf        = 1'b0;
        carry      = 1'b0;
        invalid    = 1'b0;
        case (alu_ctrl)
            CTRL_ADD: begin
                alu_result = sum_ext[MSB:0];
                ovf        = add_ovf;
                carry      = sum_ext[DATA_W];
            end
            CTRL_ADDU: begin
                alu_result = sum_ext[MSB:0];
                carry      = sum_ext[DATA_W];
            end
            CTRL_SUB: begin
                alu_result = diff_ext[MSB:0];
                ovf        = sub_ovf;
                carry      = ~diff_ext[DATA_W];
            end
            CTRL_SUBU: begin
                alu_result = diff_ext[MSB:0];
                carry      = ~diff_ext[DATA_W];
            end
            CTRL_AND:  alu_result = src_a & src_b;
            CTRL_OR:   alu_result = src_a | src_b;
            CTRL_XOR:  alu_result = src_a ^ src_b;
            CTRL_NOR:  alu_result = ~(src_a | src_b);
            CTRL_SLT:  alu_result = DATA_W'(slt);
            CTRL_SLTU: alu_result = DATA_W'(sltu);
`ifdef ALU_SHIFT_EN
            CTRL_SLL:  alu_result = src_b << shamt;
            CTRL_SRL:  alu_result = src_b >> shamt;
            CTRL_SRA:  alu_result = $unsigned($signed(src_b) >>> shamt);
`endif
            default:   invalid = 1'b1;
        endcase
    end

    // An invalid op reports only the invalid flag, even though its result is zero
    assign alu_status = {2'b00,
                         |alu_result[1:0],
                         invalid,
                         carry,
                         ovf,
                         alu_result[MSB],
                         (alu_result == '0) & ~invalid};

    // Branch-compare forwarding: the EX-stage producer has priority over MEM; r0 is never forwarded
    always_comb begin
        fwd_sel1 = 2'b00;
        if (id_ex_regwrite && (id_ex_rd != '0) && (id_ex_rd == if_id_rs))
            fwd_sel1 = 2'b01;
        else if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == if_id_rs))
            fwd_sel1 = 2'b10;
    end

    always_comb begin
        fwd_sel2 = 2'b00;
        if (id_ex_regwrite && (id_ex_rd != '0) && (id_ex_rd == if_id_rt))
            fwd_sel2 = 2'b01;
        else if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == if_id_rt))
            fwd_sel2 = 2'b10;
    end

    always_comb begin
        case (fwd_sel1)
            2'b00:   fwd_data1 = rf_data1;
            2'b01:   fwd_data1 = alu_result;
            default: fwd_data1 = mem_fwd_data;
        endcase
        case (fwd_sel2)
            2'b00:   fwd_data2 = rf_data2;
            2'b01:   fwd_data2 = alu_result;
            default: fwd_data2 = mem_fwd_data;
        endcase
    end

    assign regs_equal = (fwd_data1 == fwd_data2);

    // EX/MEM output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            status_q <= '0;
        end else if (ex_en) begin
            result_q <= alu_result;
            status_q <= alu_status;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed, table-driven bench for alu_exec_unit.
// The table covers decode, ALU results and status flags. Hand-written
// sequences then cover forwarding, the output register, ex_en hold and
// async reset. Shift vectors follow the ALU_SHIFT_EN build option.
module tb_alu_exec_unit;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NV_MAX     = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            alu_op;
    logic [5:0]            funct;
    logic [4:0]            shamt;
    logic [DATA_W-1:0]     src_a, src_b;
    logic                  ex_en;
    logic                  id_ex_regwrite, ex_mem_regwrite;
    logic [REG_ADDR_W-1:0] id_ex_rd, ex_mem_rd, if_id_rs, if_id_rt;
    logic [DATA_W-1:0]     rf_data1, rf_data2, mem_fwd_data;
    logic [3:0]            alu_ctrl;
    logic [DATA_W-1:0]     alu_result, result_q, fwd_data1, fwd_data2;
    logic [7:0]            alu_status, status_q;
    logic [1:0]            fwd_sel1, fwd_sel2;
    logic                  regs_equal;

    alu_exec_unit #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct), .shamt(shamt),
        .src_a(src_a), .src_b(src_b), .ex_en(ex_en),
        .id_ex_regwrite(id_ex_regwrite), .ex_mem_regwrite(ex_mem_regwrite),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .mem_fwd_data(mem_fwd_data),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_status(alu_status),
        .result_q(result_q), .status_q(status_q),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .regs_equal(regs_equal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic [7:0]  status;
    } vec_t;

    vec_t vecs[NV_MAX];
    int   nv = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                       input logic [31:0] result, input logic [7:0] status);
        vecs[nv].op     = op;
        vecs[nv].fn     = fn;
        vecs[nv].sh     = sh;
        vecs[nv].a      = a;
        vecs[nv].b      = b;
        vecs[nv].ctrl   = ctrl;
        vecs[nv].result = result;
        vecs[nv].status = status;
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_alu(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
        alu_op = op;
        funct  = fn;
        src_a  = a;
        src_b  = b;
    endtask

    initial begin
        // op  funct  sh  a             b             ctrl  result        status
        add(2'b10, 6'h20, 5'd0, 32'h7FFFFFFF, 32'h00000001, 4'h2, 32'h80000000, 8'h06);
        add(2'b01, 6'h00, 5'd0, 32'h00000005, 32'h00000005, 4'h6, 32'h00000000, 8'h09);
        add(2'b10, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h00000001, 4'h7, 32'h00000001, 8'h20);
        add(2'b10, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'h00000001, 4'hA, 32'h00000000, 8'h01);
        add(2'b10, 6'h2A, 5'd0, 32'h00000001, 32'hFFFFFFFF, 4'h7, 32'h00000000, 8'h01);
        add(2'b10, 6'h3F, 5'd0, 32'h12345678, 32'h9ABCDEF0, 4'hF, 32'h00000000, 8'h10);
        add(2'b00, 6'h3F, 5'd0, 32'hFFFFFFFF, 32'h00000001, 4'h2, 32'h00000000, 8'h09);
        add(2'b10, 6'h21, 5'd0, 32'h7FFFFFFF, 32'h00000001, 4'hB, 32'h80000000, 8'h02);
        add(2'b10, 6'h23, 5'd0, 32'h00000000, 32'h00000001, 4'hC, 32'hFFFFFFFF, 8'h22);
        add(2'b10, 6'h22, 5'd0, 32'h80000000, 32'h00000001, 4'h6, 32'h7FFFFFFF, 8'h2C);
        add(2'b11, 6'h22, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 4'h0, 32'hF000F000, 8'h02);
        add(2'b10, 6'h25, 5'd0, 32'h0000000C, 32'h00000003, 4'h1, 32'h0000000F, 8'h20);
        add(2'b10, 6'h26, 5'd0, 32'hFFFF0000, 32'h0F0F0F0F, 4'h3, 32'hF0F00F0F, 8'h22);
        add(2'b10, 6'h27, 5'd0, 32'h00000000, 32'h00000000, 4'h4, 32'hFFFFFFFF, 8'h22);
        add(2'b10, 6'h24, 5'd0, 32'h12345678, 32'h0000FFFF, 4'h0, 32'h00005678, 8'h00);
`ifdef ALU_SHIFT_EN
        add(2'b10, 6'h03, 5'd4, 32'h00000000, 32'hF0000000, 4'h9, 32'hFF000000, 8'h02);
        add(2'b10, 6'h00, 5'd1, 32'h00000000, 32'h80000001, 4'h5, 32'h00000002, 8'h20);
        add(2'b10, 6'h02, 5'd4, 32'h00000000, 32'hF0000000, 4'h8, 32'h0F000000, 8'h00);
`else
        add(2'b10, 6'h03, 5'd4, 32'h00000000, 32'hF0000000, 4'hF, 32'h00000000, 8'h10);
        add(2'b10, 6'h00, 5'd1, 32'h00000000, 32'h80000001, 4'hF, 32'h00000000, 8'h10);
        add(2'b10, 6'h02, 5'd4, 32'h00000000, 32'hF0000000, 4'hF, 32'h00000000, 8'h10);
`endif

        reset = 1'b1; ex_en = 1'b0; shamt = '0;
        set_alu(2'b00, 6'h00, 32'h0, 32'h0);
        id_ex_regwrite = 1'b0; ex_mem_regwrite = 1'b0;
        id_ex_rd = '0; ex_mem_rd = '0; if_id_rs = '0; if_id_rt = '0;
        rf_data1 = '0; rf_data2 = '0; mem_fwd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.result_q", result_q, 32'h0);
        check("reset.status_q", 32'(status_q), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven ALU vectors
        for (int i = 0; i < nv; i++) begin
            set_alu(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
            shamt = vecs[i].sh;
            #1;
            check($sformatf("vec%0d.ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
            check($sformatf("vec%0d.result", i), alu_result, vecs[i].result);
            check($sformatf("vec%0d.status", i), 32'(alu_status), 32'(vecs[i].status));
        end
        shamt = '0;

        // Forwarding: both sources hit EX and MEM, EX wins
        set_alu(2'b00, 6'h00, 32'd3, 32'd4);
        rf_data1 = 32'hAAAA0001; rf_data2 = 32'hAAAA0002; mem_fwd_data = 32'h00000055;
        if_id_rs = 5'd8; if_id_rt = 5'd8; id_ex_rd = 5'd8; ex_mem_rd = 5'd8;
        id_ex_regwrite = 1'b1; ex_mem_regwrite = 1'b1;
        #1;
        check("fwd_ex.sel1", 32'(fwd_sel1), 32'h1);
        check("fwd_ex.sel2", 32'(fwd_sel2), 32'h1);
        check("fwd_ex.data1", fwd_data1, 32'd7);
        check("fwd_ex.eq", 32'(regs_equal), 32'h1);
        // EX destination is r0: fall back to MEM
        id_ex_rd = 5'd0;
        #1;
        check("fwd_mem.sel1", 32'(fwd_sel1), 32'h2);
        check("fwd_mem.sel2", 32'(fwd_sel2), 32'h2);
        check("fwd_mem.data2", fwd_data2, 32'h55);
        // Split: rs from EX, rt from MEM
        if_id_rt = 5'd9; id_ex_rd = 5'd8; ex_mem_rd = 5'd9;
        #1;
        check("fwd_split.sel1", 32'(fwd_sel1), 32'h1);
        check("fwd_split.sel2", 32'(fwd_sel2), 32'h2);
        check("fwd_split.eq", 32'(regs_equal), 32'h0);
        // EX regwrite off: MEM still matches
        id_ex_regwrite = 1'b0; ex_mem_rd = 5'd8; if_id_rt = 5'd8;
        #1;
        check("fwd_noex.sel1", 32'(fwd_sel1), 32'h2);
        // r0 never forwarded, even with regwrite and matching addresses
        id_ex_regwrite = 1'b1; if_id_rs = 5'd0; if_id_rt = 5'd0;
        id_ex_rd = 5'd0; ex_mem_rd = 5'd0;
        rf_data1 = 32'h12340000; rf_data2 = 32'h12340000;
        #1;
        check("fwd_r0.sel1", 32'(fwd_sel1), 32'h0);
        check("fwd_r0.sel2", 32'(fwd_sel2), 32'h0);
        check("fwd_r0.data1", fwd_data1, 32'h12340000);
        check("fwd_r0.eq", 32'(regs_equal), 32'h1);
        // No writers at all: register file, unequal values
        id_ex_regwrite = 1'b0; ex_mem_regwrite = 1'b0; if_id_rs = 5'd3; if_id_rt = 5'd4;
        rf_data2 = 32'h12340001;
        #1;
        check("fwd_rf.data2", fwd_data2, 32'h12340001);
        check("fwd_rf.eq", 32'(regs_equal), 32'h0);

        // Output register: 1-cycle capture with ex_en
        @(negedge clk);
        set_alu(2'b01, 6'h00, 32'd5, 32'd5);
        ex_en = 1'b1;
        @(posedge clk); #1;
        check("reg_sub.result_q", result_q, 32'h0);
        check("reg_sub.status_q", 32'(status_q), 32'h09);
        @(negedge clk);
        set_alu(2'b10, 6'h20, 32'h7FFFFFFF, 32'h1);
        @(posedge clk); #1;
        check("reg_add.result_q", result_q, 32'h80000000);
        check("reg_add.status_q", 32'(status_q), 32'h06);
        // ex_en low holds the previous value
        @(negedge clk);
        ex_en = 1'b0;
        set_alu(2'b11, 6'h00, 32'h0000000F, 32'h00000003);
        @(posedge clk); #1;
        check("hold.result_q", result_q, 32'h80000000);
        check("hold.status_q", 32'(status_q), 32'h06);

        // Async reset mid-cycle with ex_en high; reset wins
        @(negedge clk);
        ex_en = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_rst.result_q", result_q, 32'h0);
        check("async_rst.status_q", 32'(status_q), 32'h0);
        @(posedge clk); #1;
        check("rst_held.result_q", result_q, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst.result_q", result_q, 32'h00000003);
        check("post_rst.status_q", 32'(status_q), 32'h20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
